// File: rtl/mode_manager_pkg.sv
// Shared definitions for the mode controller: mode codes, FSM state encodings
// and default parameter values.
package mode_manager_pkg;

   localparam logic [3:0] SPECTRUM  = 4'd0;
   localparam logic [3:0] WAVEFORM  = 4'd1;
   localparam logic [3:0] VOLUME    = 4'd2;
   localparam logic [3:0] EQUALIZER = 4'd3;
   localparam logic [3:0] BALANCE   = 4'd4;
   localparam logic [3:0] LIGHTS    = 4'd5;
   localparam logic [3:0] CLOCK     = 4'd6;
   localparam logic [3:0] ALARM     = 4'd7;
   localparam logic [3:0] PRESET    = 4'd8;
   localparam logic [3:0] CONFIG    = 4'd9;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PREVIEW = 2'd1;
   localparam logic [1:0] ST_SWITCH  = 2'd2;

   localparam int DEF_NUM_MODES       = 10;
   localparam int DEF_KEY_W           = 16;
   localparam int DEF_MODE_W          = 4;
   localparam int DEF_DEFAULT_MODE    = 0;
   localparam int DEF_WRAP            = 1;
   localparam int DEF_PREVIEW_TIMEOUT = 1000000;
   localparam int DEF_ACK_TIMEOUT     = 4096;

endpackage

// File: rtl/mode_manager_timer.sv
// Loadable down-counter; expired is high during the LIMIT-th enabled cycle
// after the last clear. LIMIT = 0 never expires.
module mode_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [CW-1:0] LOAD = CW'(LIMIT);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= LOAD;
      else if (clear)
         count_reg <= LOAD;
      else if (enable && (count_reg != '0))
         count_reg <= count_reg - ONE;
   end

   assign expired = (LIMIT != 0) && enable && !clear && (count_reg == ONE);

endmodule

// File: rtl/mode_manager.sv
// System mode controller: keypad/encoder selection with preview, and a
// request/acknowledge handshake (with optional forced commit) on every switch.
module mode_manager
   import mode_manager_pkg::*;
#(
   parameter int NUM_MODES       = DEF_NUM_MODES,
   parameter int KEY_W           = DEF_KEY_W,
   parameter int MODE_W          = DEF_MODE_W,
   parameter int DEFAULT_MODE    = DEF_DEFAULT_MODE,
   parameter int WRAP            = DEF_WRAP,
   parameter int PREVIEW_TIMEOUT = DEF_PREVIEW_TIMEOUT,
   parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEY_W-1:0]  key_pulse,
   input  logic              enc_left,
   input  logic              enc_right,
   input  logic              enc_press,
   input  logic              mode_lock,
   input  logic              mode_ack,
   output logic [MODE_W-1:0] current_mode,
   output logic [MODE_W-1:0] preview_mode,
   output logic              previewing,
   output logic              mode_req,
   output logic [MODE_W-1:0] target_mode,
   output logic              mode_change,
   output logic              ack_timeout
);

   localparam logic [MODE_W-1:0] RESET_MODE = MODE_W'(DEFAULT_MODE);
   localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
   localparam logic [MODE_W-1:0] MODE_ONE   = MODE_W'(1);

   logic [1:0]        state_reg, state_next;
   logic [MODE_W-1:0] current_reg, current_next;
   logic [MODE_W-1:0] preview_reg, preview_next;
   logic [MODE_W-1:0] target_reg, target_next;
   logic              change_reg, change_next;
   logic              timeout_reg, timeout_next;

   logic              key_hit, key_valid;
   logic [MODE_W-1:0] key_mode;
   logic              enc_step;
   logic [MODE_W-1:0] step_base, step_mode;
   logic              preview_expired, ack_expired;

   // Only a lone pulse on an in-range bit counts as a key press.
   always_comb begin
      key_hit  = 1'b0;
      key_mode = '0;
      for (int i = 0; i < NUM_MODES; i++) begin
         if (key_pulse[i]) begin
            key_hit  = 1'b1;
            key_mode = MODE_W'(i);
         end
      end
      key_valid = key_hit && $onehot(key_pulse);
   end

   assign enc_step = enc_left ^ enc_right;

   always_comb begin
      step_base = (state_reg == ST_PREVIEW) ? preview_reg : current_reg;
      step_mode = step_base;
      if (enc_right) begin
         if (step_base == LAST_MODE)
            step_mode = (WRAP != 0) ? '0 : LAST_MODE;
         else
            step_mode = step_base + MODE_ONE;
      end else begin
         if (step_base == '0)
            step_mode = (WRAP != 0) ? LAST_MODE : '0;
         else
            step_mode = step_base - MODE_ONE;
      end
   end

   mode_timer #(.LIMIT(PREVIEW_TIMEOUT)) u_preview_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   ((state_reg != ST_PREVIEW) || enc_step),
      .enable  (state_reg == ST_PREVIEW),
      .expired (preview_expired)
   );

   mode_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_reg != ST_SWITCH),
      .enable  (state_reg == ST_SWITCH),
      .expired (ack_expired)
   );

   always_comb begin
      state_next   = state_reg;
      current_next = current_reg;
      preview_next = preview_reg;
      target_next  = target_reg;
      change_next  = 1'b0;
      timeout_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!mode_lock) begin
               if (key_valid) begin
                  if (key_mode != current_reg) begin
                     target_next = key_mode;
                     state_next  = ST_SWITCH;
                  end
               end else if (enc_step) begin
                  preview_next = step_mode;
                  state_next   = ST_PREVIEW;
               end
            end
         end
         ST_PREVIEW: begin
            if (mode_lock) begin
               preview_next = current_reg;
               state_next   = ST_IDLE;
            end else if (key_valid) begin
               preview_next = current_reg;
               if (key_mode == current_reg) begin
                  state_next = ST_IDLE;
               end else begin
                  target_next = key_mode;
                  state_next  = ST_SWITCH;
               end
            end else if (enc_press) begin
               if (preview_reg == current_reg) begin
                  state_next = ST_IDLE;
               end else begin
                  target_next = preview_reg;
                  state_next  = ST_SWITCH;
               end
            end else if (enc_step) begin
               preview_next = step_mode;
            end else if (preview_expired) begin
               preview_next = current_reg;
               state_next   = ST_IDLE;
            end
         end
         ST_SWITCH: begin
            // An ack in the same cycle as the timeout is a normal commit.
            if (mode_ack || ack_expired) begin
               current_next = target_reg;
               preview_next = target_reg;
               change_next  = 1'b1;
               timeout_next = !mode_ack;
               state_next   = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         current_reg <= RESET_MODE;
         preview_reg <= RESET_MODE;
         target_reg  <= RESET_MODE;
         change_reg  <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         current_reg <= current_next;
         preview_reg <= preview_next;
         target_reg  <= target_next;
         change_reg  <= change_next;
         timeout_reg <= timeout_next;
      end
   end

   assign current_mode = current_reg;
   assign preview_mode = preview_reg;
   assign target_mode  = target_reg;
   assign previewing   = (state_reg == ST_PREVIEW);
   assign mode_req     = (state_reg == ST_SWITCH);
   assign mode_change  = change_reg;
   assign ack_timeout  = timeout_reg;

endmodule

// File: tb/tb_mode_manager.sv
// Bench for mode_manager: a wrapping and a saturating instance share stimulus and
// are compared every cycle against a rule-level reference model.
module tb_mode_manager;

   localparam int NM  = 10;
   localparam int KW  = 16;
   localparam int MW  = 4;
   localparam int DEF = 0;
   localparam int PT  = 16;
   localparam int AT  = 8;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_PREV = 2'd1;
   localparam logic [1:0] M_SW   = 2'd2;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] cur;
      logic [3:0] prev;
      logic [3:0] tgt;
      int         idle;
      int         wcnt;
      logic       chg;
      logic       tmo;
   } mdl_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [KW-1:0] key_pulse;
   logic          enc_left, enc_right, enc_press, mode_lock, mode_ack;

   logic [MW-1:0] cur_w, prev_w, tgt_w, cur_s, prev_s, tgt_s;
   logic          pv_w, req_w, chg_w, tmo_w, pv_s, req_s, chg_s, tmo_s;

   int   checks   = 0;
   int   failures = 0;
   mdl_t mw, ms;

   always #5 clk = ~clk;

   mode_manager #(.NUM_MODES(NM), .KEY_W(KW), .MODE_W(MW), .DEFAULT_MODE(DEF), .WRAP(1),
                  .PREVIEW_TIMEOUT(PT), .ACK_TIMEOUT(AT)) dut_w (
      .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .enc_left(enc_left),
      .enc_right(enc_right), .enc_press(enc_press), .mode_lock(mode_lock), .mode_ack(mode_ack),
      .current_mode(cur_w), .preview_mode(prev_w), .previewing(pv_w), .mode_req(req_w),
      .target_mode(tgt_w), .mode_change(chg_w), .ack_timeout(tmo_w)
   );

   mode_manager #(.NUM_MODES(NM), .KEY_W(KW), .MODE_W(MW), .DEFAULT_MODE(DEF), .WRAP(0),
                  .PREVIEW_TIMEOUT(PT), .ACK_TIMEOUT(AT)) dut_s (
      .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .enc_left(enc_left),
      .enc_right(enc_right), .enc_press(enc_press), .mode_lock(mode_lock), .mode_ack(mode_ack),
      .current_mode(cur_s), .preview_mode(prev_s), .previewing(pv_s), .mode_req(req_s),
      .target_mode(tgt_s), .mode_change(chg_s), .ack_timeout(tmo_s)
   );

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.st   = M_IDLE;
      m.cur  = 4'(DEF);
      m.prev = 4'(DEF);
      m.tgt  = 4'(DEF);
      m.idle = 0;
      m.wcnt = 0;
      m.chg  = 1'b0;
      m.tmo  = 1'b0;
      return m;
   endfunction

   function automatic logic [3:0] move(input logic [3:0] b, input int d, input bit wrap);
      int t;
      t = int'(b) + d;
      if (wrap) t = (t + NM) % NM;
      else if (t < 0) t = 0;
      else if (t > NM - 1) t = NM - 1;
      return t[3:0];
   endfunction

   function automatic mdl_t mdl_next(input mdl_t m, input bit wrap, input logic [KW-1:0] key,
                                     input logic l, input logic r, input logic p,
                                     input logic lock, input logic ack);
      mdl_t n;
      int   idx;
      bit   kv, step;
      int   dir;
      n     = m;
      n.chg = 1'b0;
      n.tmo = 1'b0;
      idx   = 0;
      for (int i = 0; i < KW; i++) if (key[i]) idx = i;
      kv   = ($countones(key) == 1) && (idx < NM);
      step = (l != r);
      dir  = r ? 1 : -1;
      case (m.st)
         M_IDLE: begin
            if (!lock) begin
               if (kv) begin
                  if (idx != int'(m.cur)) begin n.tgt = 4'(idx); n.st = M_SW; n.wcnt = 0; end
               end else if (step) begin
                  n.prev = move(m.cur, dir, wrap); n.st = M_PREV; n.idle = 0;
               end
            end
         end
         M_PREV: begin
            if (lock) begin
               n.prev = m.cur; n.st = M_IDLE;
            end else if (kv) begin
               n.prev = m.cur;
               if (idx == int'(m.cur)) n.st = M_IDLE;
               else begin n.tgt = 4'(idx); n.st = M_SW; n.wcnt = 0; end
            end else if (p) begin
               if (m.prev == m.cur) n.st = M_IDLE;
               else begin n.tgt = m.prev; n.st = M_SW; n.wcnt = 0; end
            end else if (step) begin
               n.prev = move(m.prev, dir, wrap); n.idle = 0;
            end else if (m.idle + 1 >= PT) begin
               n.prev = m.cur; n.st = M_IDLE;
            end else begin
               n.idle = m.idle + 1;
            end
         end
         default: begin
            n.wcnt = m.wcnt + 1;
            if (ack || (AT != 0 && n.wcnt >= AT)) begin
               n.cur = m.tgt; n.prev = m.tgt; n.chg = 1'b1; n.tmo = !ack; n.st = M_IDLE;
            end
         end
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("w_current", 32'(cur_w), 32'(mw.cur));
      chk("w_preview", 32'(prev_w), 32'(mw.prev));
      chk("w_previewing", 32'(pv_w), 32'(mw.st == M_PREV));
      chk("w_mode_req", 32'(req_w), 32'(mw.st == M_SW));
      chk("w_target", 32'(tgt_w), 32'(mw.tgt));
      chk("w_mode_change", 32'(chg_w), 32'(mw.chg));
      chk("w_ack_timeout", 32'(tmo_w), 32'(mw.tmo));
      chk("s_current", 32'(cur_s), 32'(ms.cur));
      chk("s_preview", 32'(prev_s), 32'(ms.prev));
      chk("s_previewing", 32'(pv_s), 32'(ms.st == M_PREV));
      chk("s_mode_req", 32'(req_s), 32'(ms.st == M_SW));
      chk("s_target", 32'(tgt_s), 32'(ms.tgt));
      chk("s_mode_change", 32'(chg_s), 32'(ms.chg));
      chk("s_ack_timeout", 32'(tmo_s), 32'(ms.tmo));
   endtask

   // Advance one clock: model sees the same inputs as the DUTs at the edge,
   // outputs are compared 1 time unit later, then single-cycle pulses drop.
   task automatic tick();
      @(posedge clk);
      mw = mdl_next(mw, 1'b1, key_pulse, enc_left, enc_right, enc_press, mode_lock, mode_ack);
      ms = mdl_next(ms, 1'b0, key_pulse, enc_left, enc_right, enc_press, mode_lock, mode_ack);
      #1;
      check_all();
      key_pulse = '0;
      enc_left  = 1'b0;
      enc_right = 1'b0;
      enc_press = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst_n     = 1'b0;
      key_pulse = '0;
      enc_left  = 1'b0;
      enc_right = 1'b0;
      enc_press = 1'b0;
      mode_lock = 1'b0;
      mode_ack  = 1'b1;
      mw = mdl_reset();
      ms = mdl_reset();
      repeat (3) @(negedge clk);
      $display("step: reset values");
      check_all();
      chk("reset_current", 32'(cur_w), 32'(DEF));
      chk("reset_mode_req", 32'(req_w), 32'd0);
      rst_n = 1'b1;

      $display("step: key 0x0008 with ack tied high");
      key_pulse = 16'h0008;
      tick();
      chk("t1_req_next_cycle", 32'(req_w), 32'd1);
      tick();
      chk("t1_commit_mode", 32'(cur_w), 32'd3);
      chk("t1_change_pulse", 32'(chg_w), 32'd1);
      tick();
      chk("t1_change_one_cycle", 32'(chg_w), 32'd0);

      $display("step: two-bit key then out-of-range key");
      key_pulse = 16'h0C00;
      tick();
      key_pulse = 16'h0400;
      tick();
      chk("t2_no_req", 32'(req_w), 32'd0);
      chk("t2_mode_kept", 32'(cur_w), 32'd3);

      $display("step: go to mode 9, encoder right x2, press");
      key_pulse = 16'h0200;
      tick();
      tick();
      enc_right = 1'b1;
      tick();
      chk("t3_wrap_preview0", 32'(prev_w), 32'd0);
      chk("t3_sat_preview9", 32'(prev_s), 32'd9);
      enc_right = 1'b1;
      tick();
      chk("t3_wrap_preview1", 32'(prev_w), 32'd1);
      enc_press = 1'b1;
      tick();
      chk("t3_sat_back_idle", 32'(pv_s), 32'd0);
      tick();
      chk("t3_wrap_commit1", 32'(cur_w), 32'd1);
      chk("t3_sat_no_change", 32'(chg_s), 32'd0);
      tick();

      $display("step: preview left then idle until timeout");
      enc_left = 1'b1;
      tick();
      repeat (PT - 1) tick();
      chk("t4_still_preview", 32'(pv_w), 32'd1);
      tick();
      chk("t4_preview_dropped", 32'(pv_w), 32'd0);
      chk("t4_preview_restored", 32'(prev_w), 32'(cur_w));
      tick();

      $display("step: ack held low, lock during switch");
      mode_ack  = 1'b0;
      key_pulse = 16'h0004;
      tick();
      mode_lock = 1'b1;
      repeat (AT - 1) tick();
      chk("t5_waiting", 32'(req_w), 32'd1);
      tick();
      chk("t5_forced_commit", 32'(cur_w), 32'd2);
      chk("t5_ack_timeout", 32'(tmo_w), 32'd1);
      key_pulse = 16'h0010;
      tick();
      key_pulse = 16'h0010;
      tick();
      chk("t5_locked_key", 32'(req_w), 32'd0);
      mode_lock = 1'b0;
      tick();

      $display("step: reset during switch");
      key_pulse = 16'h0020;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_req_async_drop", 32'(req_w), 32'd0);
      chk("t6_mode_async_reset", 32'(cur_w), 32'(DEF));
      chk("t6_s_mode_async_reset", 32'(cur_s), 32'(DEF));
      mw = mdl_reset();
      ms = mdl_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("step: randomized traffic");
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 6) key_pulse = 16'd1 << $urandom_range(0, NM - 1);
         else if (r < 8) key_pulse = 16'd1 << $urandom_range(NM, KW - 1);
         else if (r < 9) key_pulse = 16'($urandom);
         else key_pulse = '0;
         enc_left  = ($urandom_range(0, 99) < 10);
         enc_right = ($urandom_range(0, 99) < 10);
         enc_press = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) < 3) mode_lock = ~mode_lock;
         mode_ack = ($urandom_range(0, 99) < 35);
         if ((n % 150) > 120) begin
            key_pulse = '0;
            enc_left  = 1'b0;
            enc_right = 1'b0;
            enc_press = 1'b0;
            mode_lock = 1'b0;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
